// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Optional same-cycle bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
package fetch_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int FQ_DEPTH = 4;

    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

    // Value presented at the head whenever nothing valid is available.
    function automatic fetch_entry_t nop_entry();
        fetch_entry_t e;
        e.pc    = '0;
        e.instr = NOP_INSTR;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: IF push side, ID pop side, flush and occupancy.
// master = IF/ID environment, slave = the queue itself.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                flush;
    logic                in_valid;
    logic [ADDR_W-1:0]   in_pc;
    logic [DATA_W-1:0]   in_instr;
    logic                in_ready;
    logic                out_valid;
    logic [ADDR_W-1:0]   out_pc;
    logic [DATA_W-1:0]   out_instr;
    logic                out_ready;
    logic [CW-1:0]       count;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );

endinterface

// File: rtl/fetch_queue_ptr.sv
// Wrapping pointer counter (modulo 2**W) with synchronous clear taking priority over increment.
module fq_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (clr) begin
            ptr_reg <= '0;
        end else if (inc) begin
            ptr_reg <= ptr_reg + 1'b1;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between IF and ID with flush on taken branch.
// Define FETCH_QUEUE_BYPASS_EN for same-cycle pass-through when the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.slave  q
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          full;
    logic          empty;
    logic          in_ready;
    logic          bypass;
    logic          push;
    logic          pop;

    fetch_entry_t  mem [DEPTH];
    fetch_entry_t  in_entry;
    fetch_entry_t  head_entry;

    assign full  = (cnt_reg == CW'(DEPTH));
    assign empty = (cnt_reg == '0);

    // in_ready ignores a concurrent pop so the write never races the read slot.
    assign in_ready = ~full & ~q.flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & q.in_valid & q.out_ready & ~q.flush;
`else
    assign bypass = 1'b0;
`endif

    assign push = q.in_valid & in_ready & ~bypass;
    assign pop  = ~empty & q.out_ready & ~q.flush;

    assign in_entry.pc    = q.in_pc;
    assign in_entry.instr = q.in_instr;

    always_comb begin
        head_entry = nop_entry();
        if (bypass) begin
            head_entry = in_entry;
        end else if (!empty) begin
            head_entry = mem[rd_ptr];
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (q.flush) begin
            cnt_next = '0;
        end else if (push && !pop) begin
            cnt_next = cnt_reg + 1'b1;
        end else if (pop && !push) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    fq_ptr #(.W(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (q.flush),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    fq_ptr #(.W(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (q.flush),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    // Storage is deliberately unreset; empty slots are masked by the head mux.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (push && (wr_ptr == PW'(gi))) begin
                    mem[gi] <= in_entry;
                end
            end
        end
    endgenerate

    assign q.in_ready  = in_ready;
    assign q.out_valid = ~empty | bypass;
    assign q.out_pc    = head_entry.pc;
    assign q.out_instr = head_entry.instr;
    assign q.count     = cnt_reg;

endmodule
